// File: rtl/tdp_ram_if.sv
// tdp_ram_if: access bundle for the true dual-port RAM.
//   clr/busy           memory-clear request and clear-engine status
//   en/wen/be/a/di x   port x access enable, write enable, byte enables, address, write data
//   do/vld x           port x registered read data and its valid flag
//   coll               write-write collision pulse
// The master modport drives requests; the slave modport is the RAM side.
interface tdp_ram_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) ();
    localparam int unsigned NB = DW / 8;

    logic          clr;
    logic          busy;

    logic          en0;
    logic          wen0;
    logic [NB-1:0] be0;
    logic [AW-1:0] a0;
    logic [DW-1:0] di0;
    logic [DW-1:0] do0;
    logic          vld0;

    logic          en1;
    logic          wen1;
    logic [NB-1:0] be1;
    logic [AW-1:0] a1;
    logic [DW-1:0] di1;
    logic [DW-1:0] do1;
    logic          vld1;

    logic          coll;

    modport master (
        output clr, en0, wen0, be0, a0, di0, en1, wen1, be1, a1, di1,
        input  busy, do0, vld0, do1, vld1, coll
    );

    modport slave (
        input  clr, en0, wen0, be0, a0, di0, en1, wen1, be1, a1, di1,
        output busy, do0, vld0, do1, vld1, coll
    );
endinterface

// File: rtl/tdp_ram_ctrl.sv
// tdp_ram_ctrl: true dual-port RAM with byte enables, registered reads,
// selectable same-port read-during-write, deterministic write-write collision
// resolution (port 0 wins per byte lane) and a sequenced memory-clear engine.
//   clk    rising-edge clock shared by both ports
//   rst_n  asynchronous active-low reset (memory contents are kept)
//   bus    slave side of tdp_ram_if (both ports, clear control, status)
module tdp_ram_ctrl #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned RDW_MODE = 0
) (
    input logic        clk,
    input logic        rst_n,
    tdp_ram_if.slave   bus
);
    localparam int unsigned NB = DW / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    logic [DW-1:0] mem [DEPTH];

    logic          acc0, acc1;
    logic          rng0, rng1;
    logic          wr0, wr1;
    logic          coll_addr;
    logic [DW-1:0] old0, old1;
    logic [DW-1:0] new0, new1;
    logic [DW-1:0] rd0, rd1;

    logic [DW-1:0] do0_q, do1_q;
    logic          vld0_q, vld1_q;
    logic          coll_q;
    logic          busy_q;

    // Overlay the enabled byte lanes of wdat onto base.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] base,
                                            input logic [DW-1:0] wdat,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = base;
        for (int b = 0; b < int'(NB); b++) begin
            if (be[b]) r[8*b +: 8] = wdat[8*b +: 8];
        end
        return r;
    endfunction

    // State register for the clear engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Clear engine next state: one word per cycle, 0..DEPTH-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Access decode, collision resolution and read-data selection.
    // On a collision, port 1's merge is applied first and port 0's on top,
    // so port 0 owns every lane it enables; the combined word goes through
    // port 0's write path and port 1's write is suppressed.
    always_comb begin
        acc0      = (state == IDLE) && !bus.clr && bus.en0;
        acc1      = (state == IDLE) && !bus.clr && bus.en1;
        rng0      = 32'(bus.a0) < DEPTH;
        rng1      = 32'(bus.a1) < DEPTH;
        old0      = '0;
        old1      = '0;
        if (rng0) old0 = mem[bus.a0];
        if (rng1) old1 = mem[bus.a1];
        wr0       = acc0 && bus.wen0 && rng0;
        wr1       = acc1 && bus.wen1 && rng1;
        coll_addr = wr0 && wr1 && (bus.a0 == bus.a1);
        new0      = merge(old0, bus.di0, bus.be0);
        new1      = merge(old1, bus.di1, bus.be1);
        if (coll_addr) begin
            new0 = merge(new1, bus.di0, bus.be0);
            new1 = new0;
        end
        // Cross-port reads always see the pre-edge word (old0/old1).
        rd0 = old0;
        rd1 = old1;
        if (RDW_MODE == 1 && wr0) rd0 = new0;
        if (RDW_MODE == 1 && wr1) rd1 = new1;
    end

    // Memory array: clear engine has exclusive use while running.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0)              mem[bus.a0] <= new0;
            if (wr1 && !coll_addr) mem[bus.a1] <= new1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do0_q  <= '0;
            do1_q  <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
            coll_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            vld0_q <= acc0;
            vld1_q <= acc1;
            if (acc0) do0_q <= rd0;
            if (acc1) do1_q <= rd1;
            coll_q <= coll_addr && (|(bus.be0 & bus.be1));
            busy_q <= (state_nxt == CLEAR);
        end
    end

    assign bus.do0  = do0_q;
    assign bus.do1  = do1_q;
    assign bus.vld0 = vld0_q;
    assign bus.vld1 = vld1_q;
    assign bus.coll = coll_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_tdp_ram_ctrl.sv
// tb_tdp_ram_ctrl: directed bench for tdp_ram_ctrl.
// u_a: DW=32, DEPTH=12, read-first.  u_b: DW=16, DEPTH=12, write-first.
module tb_tdp_ram_ctrl;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    tdp_ram_if #(.DW(32), .AW(4)) bus_a ();
    tdp_ram_if #(.DW(16), .AW(4)) bus_b ();

    tdp_ram_ctrl #(.DW(32), .AW(4), .DEPTH(12), .RDW_MODE(0)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    tdp_ram_ctrl #(.DW(16), .AW(4), .DEPTH(12), .RDW_MODE(1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic a_p0(input int en, input int wen, input int be, input int a, input logic [31:0] di);
        bus_a.en0 = 1'(en); bus_a.wen0 = 1'(wen); bus_a.be0 = 4'(be);
        bus_a.a0 = 4'(a); bus_a.di0 = di;
    endtask

    task automatic a_p1(input int en, input int wen, input int be, input int a, input logic [31:0] di);
        bus_a.en1 = 1'(en); bus_a.wen1 = 1'(wen); bus_a.be1 = 4'(be);
        bus_a.a1 = 4'(a); bus_a.di1 = di;
    endtask

    task automatic b_p0(input int en, input int wen, input int be, input int a, input logic [15:0] di);
        bus_b.en0 = 1'(en); bus_b.wen0 = 1'(wen); bus_b.be0 = 2'(be);
        bus_b.a0 = 4'(a); bus_b.di0 = di;
    endtask

    task automatic b_p1(input int en, input int wen, input int be, input int a, input logic [15:0] di);
        bus_b.en1 = 1'(en); bus_b.wen1 = 1'(wen); bus_b.be1 = 2'(be);
        bus_b.a1 = 4'(a); bus_b.di1 = di;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus_a.clr = 1'b0;
        bus_b.clr = 1'b0;
        a_p0(0, 0, 0, 0, 32'h0); a_p1(0, 0, 0, 0, 32'h0);
        b_p0(0, 0, 0, 0, 16'h0); b_p1(0, 0, 0, 0, 16'h0);
        #2;
        // Reset values
        chk("rst_do0",  bus_a.do0, 32'h0);
        chk("rst_do1",  bus_a.do1, 32'h0);
        chk("rst_vld0", 32'(bus_a.vld0), 32'h0);
        chk("rst_busy", 32'(bus_a.busy), 32'h0);
        chk("rst_coll", 32'(bus_b.coll), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic read latency
        a_p0(1, 1, 4'hF, 3, 32'hA5);
        tick();
        chk("wr_vld0", 32'(bus_a.vld0), 32'h1);
        a_p0(0, 0, 0, 0, 32'h0);
        a_p1(1, 0, 0, 3, 32'h0);
        tick();
        chk("rd_do1", bus_a.do1, 32'hA5);
        chk("rd_vld1", 32'(bus_a.vld1), 32'h1);
        a_p1(0, 0, 0, 0, 32'h0);
        tick();
        chk("idle_vld1", 32'(bus_a.vld1), 32'h0);
        chk("hold_do1", bus_a.do1, 32'hA5);

        // Byte lanes
        a_p0(1, 1, 4'hF, 5, 32'h11223344);
        tick();
        a_p0(0, 0, 0, 0, 32'h0);
        a_p1(1, 1, 4'b0101, 5, 32'hAABBCCDD);
        tick();
        a_p1(1, 0, 0, 5, 32'h0);
        tick();
        chk("byte_lanes", bus_a.do1, 32'h11BB33DD);
        a_p1(0, 0, 0, 0, 32'h0);

        // Read-during-write, read-first (u_a)
        a_p0(1, 1, 4'hF, 2, 32'h10);
        tick();
        a_p0(1, 1, 4'hF, 2, 32'h20);
        a_p1(1, 0, 0, 2, 32'h0);
        tick();
        chk("rdw0_same", bus_a.do0, 32'h10);
        chk("rdw0_cross", bus_a.do1, 32'h10);
        a_p1(0, 0, 0, 0, 32'h0);
        a_p0(1, 0, 0, 2, 32'h0);
        tick();
        chk("rdw0_after", bus_a.do0, 32'h20);
        a_p0(0, 0, 0, 0, 32'h0);

        // Read-during-write, write-first (u_b)
        b_p0(1, 1, 2'b11, 2, 16'h10);
        tick();
        b_p0(1, 1, 2'b11, 2, 16'h20);
        b_p1(1, 0, 0, 2, 16'h0);
        tick();
        chk("rdw1_same", 32'(bus_b.do0), 32'h20);
        chk("rdw1_cross", 32'(bus_b.do1), 32'h10);

        // Collisions (u_b, addr 7)
        b_p0(1, 1, 2'b01, 7, 16'h1111);
        b_p1(1, 1, 2'b11, 7, 16'h2222);
        tick();
        chk("coll1_flag", 32'(bus_b.coll), 32'h1);
        chk("coll1_do0", 32'(bus_b.do0), 32'h2211);
        chk("coll1_do1", 32'(bus_b.do1), 32'h2211);
        b_p0(1, 1, 2'b10, 7, 16'h1111);
        b_p1(1, 1, 2'b01, 7, 16'h2222);
        tick();
        chk("coll2_flag", 32'(bus_b.coll), 32'h0);
        chk("coll2_do0", 32'(bus_b.do0), 32'h1122);
        b_p0(1, 0, 0, 7, 16'h0);
        b_p1(0, 0, 0, 0, 16'h0);
        tick();
        chk("coll2_mem", 32'(bus_b.do0), 32'h1122);
        chk("coll_pulse_end", 32'(bus_b.coll), 32'h0);
        b_p0(0, 0, 0, 0, 16'h0);

        // Out-of-range
        a_p0(1, 0, 0, 13, 32'h0);
        tick();
        chk("oor_rd_do", bus_a.do0, 32'h0);
        chk("oor_rd_vld", 32'(bus_a.vld0), 32'h1);
        a_p0(1, 1, 4'hF, 13, 32'h01010101);
        a_p1(1, 1, 4'hF, 13, 32'hDEADBEEF);
        tick();
        chk("oor_coll", 32'(bus_a.coll), 32'h0);
        chk("oor_wr_do1", bus_a.do1, 32'h0);
        a_p0(1, 0, 0, 13, 32'h0);
        a_p1(1, 0, 0, 5, 32'h0);
        tick();
        chk("oor_after", bus_a.do0, 32'h0);
        chk("oor_no_alias", bus_a.do1, 32'h11BB33DD);
        a_p0(0, 0, 0, 0, 32'h0);
        a_p1(0, 0, 0, 0, 32'h0);

        // Clear engine
        for (int i = 0; i < 12; i++) begin
            a_p0(1, 1, 4'hF, i, 32'hFF);
            tick();
        end
        a_p0(0, 0, 0, 0, 32'h0);
        bus_a.clr = 1'b1;
        a_p1(1, 0, 0, 4, 32'h0);
        tick();
        bus_a.clr = 1'b0;
        chk("clr_busy_start", 32'(bus_a.busy), 32'h1);
        chk("clr_req_ignored", 32'(bus_a.vld1), 32'h0);
        for (int k = 1; k < 12; k++) begin
            tick();
            chk($sformatf("clr_busy_%0d", k), 32'(bus_a.busy), 32'h1);
            chk($sformatf("clr_vld_%0d", k), 32'(bus_a.vld1), 32'h0);
        end
        tick();
        chk("clr_busy_end", 32'(bus_a.busy), 32'h0);
        chk("clr_vld_end", 32'(bus_a.vld1), 32'h0);
        a_p1(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            a_p0(1, 0, 0, i, 32'h0);
            tick();
            chk($sformatf("clr_word_%0d", i), bus_a.do0, 32'h0);
        end
        a_p0(0, 0, 0, 0, 32'h0);

        // Reset mid-clear
        for (int i = 0; i < 12; i++) begin
            a_p0(1, 1, 4'hF, i, 32'hFF);
            tick();
        end
        a_p0(1, 0, 0, 0, 32'h0);
        tick();
        chk("pre_rst_do0", bus_a.do0, 32'hFF);
        a_p0(0, 0, 0, 0, 32'h0);
        bus_a.clr = 1'b1;
        tick();
        bus_a.clr = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_busy", 32'(bus_a.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus_a.busy), 32'h0);
        chk("arst_do0", bus_a.do0, 32'h0);
        chk("arst_vld0", 32'(bus_a.vld0), 32'h0);
        chk("arst_coll", 32'(bus_a.coll), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_p0(1, 0, 0, i, 32'h0);
            tick();
            chk($sformatf("partial_word_%0d", i), bus_a.do0, (i < 5) ? 32'h0 : 32'hFF);
        end
        a_p0(0, 0, 0, 0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tdp_ram_ctrl.md
Name: tdp_ram_ctrl

Overview:
Parametrised true dual-port RAM. It is the next generation of the team's single-write dual-port RAM. Two fully independent ports share one clock, and each port can read or write. Additions over the previous block:
- per-byte write enables
- registered reads with a valid flag
- a selectable read-during-write mode
- deterministic write-write collision resolution with a collision flag
- a sequenced memory-clear engine

It sits between datapath blocks as a shared scratch or ping-pong buffer.

Parameters:
DW, 8, data width in bits; must be a multiple of 8; NB = DW/8 byte lanes
AW, 4, address width
DEPTH, 16, number of words; must be ≤ 2^AW
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old word), 1 = write-first (merged new word)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
CLR  in  1  request to zero the whole memory (sampled in IDLE only)
BUSY  out  1  clear engine running; all port accesses ignored
EN0  in  1  port 0 access enable
WEN0  in  1  port 0 write (valid with EN0)
BE0  in  NB  port 0 byte enables
A0  in  AW  port 0 address
DI0  in  DW  port 0 write data
DO0  out  DW  port 0 registered read data
VLD0  out  1  DO0 updated this cycle
EN1, WEN1, BE1, A1, DI1, DO1, VLD1: same as port 0, for port 1
COLL  out  1  one-cycle pulse: write-write collision occurred on the previous edge

Behaviour:
- Reset (RST_N low, asynchronous):
  - DO0, DO1 = 0; VLD0, VLD1, COLL, BUSY = 0.
  - FSM = IDLE; clear counter = 0.
  - RAM contents are not affected by reset.
- FSM states: IDLE and CLEAR.
  - IDLE → CLEAR on an edge with CLR=1. Port accesses presented on that same edge are ignored.
  - CLEAR writes 0 to address cnt on each edge; cnt runs 0..DEPTH-1.
  - After the write to DEPTH-1, the next state is IDLE.
  - BUSY is 1 exactly while the state is CLEAR, i.e. DEPTH cycles.
  - CLR is ignored while in CLEAR.
- Read (ENx=1 in IDLE, CLR=0):
  - DOx is loaded at the edge and VLDx=1 the following cycle. Latency is 1.
  - If ENx=0 or BUSY=1, VLDx=0 and DOx holds its previous value.
- Write (ENx=1, WENx=1):
  - Byte lane b of word Ax is updated from DIx[8b+7:8b] only where BEx[b]=1.
  - BEx=0 is a no-op write, but a read still occurs (VLDx=1).
- Same-port read during write:
  - RDW_MODE=0: DOx = word before the write.
  - RDW_MODE=1: DOx = post-write merged word.
- Cross-port (port y writes the address port x reads, same edge): DOx always returns the old word, independent of RDW_MODE.
- Write-write collision (EN0=EN1=WEN0=WEN1=1, A0==A1, address in range):
  - Lanes with BE0=1 take DI0 (port 0 wins).
  - Lanes with only BE1=1 take DI1.
  - COLL=1 for one cycle after the edge whenever BE0&BE1 is nonzero; otherwise COLL=0.
  - RDW_MODE=1 write-first readback on either port returns the final resolved word.
- Out-of-range address (Ax ≥ DEPTH): the write is dropped, DOx = 0, VLDx=1. It never participates in a collision.
- Asynchronous reset mid-CLEAR: the clear is aborted, BUSY=0 immediately, and memory is left partially cleared.

Test Plan:
- Basic read latency: write 0xA5 to addr 3 via port 0, then EN1=1, A1=3 → next cycle DO1=0xA5, VLD1=1; cycle after with EN1=0 → VLD1=0, DO1 holds 0xA5.
- Byte lanes (DW=32): mem[5]=0x11223344; port 1 writes DI1=0xAABBCCDD with BE1=4'b0101 → read gives 0x11BB33DD.
- Read-during-write (mem[2]=0x10; port 0 writes 0x20 to addr 2 with read):
  - RDW_MODE=0 → DO0=0x10.
  - RDW_MODE=1 → DO0=0x20.
  - Both modes: port 1 reading addr 2 on the same edge gets 0x10.
- Collision (DW=16, addr 7): DI0=0x1111 BE0=2'b01, DI1=0x2222 BE1=2'b11 → mem[7]=0x2211, COLL=1 for one cycle; repeat with BE0=2'b10, BE1=2'b01 → COLL=0, mem[7]=0x1122.
- Clear (DEPTH=12, AW=4): fill all words with 0xFF, pulse CLR → BUSY high 12 cycles, reads during BUSY give VLD=0; after BUSY falls all 12 words read 0. Read of addr 13 → DO=0, VLD=1; a write to addr 13 changes nothing.
- Reset mid-clear: assert RST_N low at clear cycle 5 → BUSY, VLD, COLL, DO drop to 0 asynchronously; words 0–4 read 0 and words 5–11 read 0xFF after reset release.
